// File: rtl/dual_issue_stage.sv
// Dual-issue stage: routes a fetched instruction pair to the even/odd pipes and splits the pair on structural or RAW hazards.
// Optional macro ISSUE_STATS_EN adds saturating dual/single issue counters.
module dual_issue_stage #(
  parameter logic [31:0] NOP_EVEN = 32'h0020_0000,
  parameter logic [31:0] NOP_ODD  = 32'h4020_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] first_inst,
  input  logic [31:0] second_inst,
  input  logic [31:0] pc_in,
  input  logic        flush,
  input  logic        stall_in,
  output logic        stall_out,
  output logic [31:0] even_inst,
  output logic [31:0] even_pc,
  output logic        even_valid,
  output logic [31:0] odd_inst,
  output logic [31:0] odd_pc,
  output logic        odd_valid
`ifdef ISSUE_STATS_EN
  ,
  output logic [31:0] dual_issue_cnt,
  output logic [31:0] single_issue_cnt
`endif
);

  typedef enum logic {PAIR, HOLD} state_t;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        valid;
  } slot_t;

  // Instruction bit 0 is the MSB, so opcode [0:10] is [31:21] here and pipe bit [1] is [30].
  function automatic logic is_nop(input logic [10:0] opcode);
    return (opcode == 11'b00000000001) || (opcode == 11'b01000000001);
  endfunction

  state_t      state;
  logic [31:0] hold_inst;
  logic [31:0] hold_pc;

  logic        first_nop, second_nop;
  logic        raw_hz, struct_hz, hazard;
  logic [31:0] second_pc;

  assign first_nop  = is_nop(first_inst[31:21]);
  assign second_nop = is_nop(second_inst[31:21]);
  assign second_pc  = pc_in + 32'd4;
  assign raw_hz     = (second_inst[13:7] == first_inst[6:0]) || (second_inst[20:14] == first_inst[6:0]);
  assign struct_hz  = (first_inst[30] == second_inst[30]);
  assign hazard     = !first_nop && !second_nop && (raw_hz || struct_hz);

  assign stall_out  = stall_in || ((state == PAIR) && hazard && !flush);

  // Candidate instructions for this cycle: the held one alone, the first alone, or the full pair.
  logic [31:0] c0_inst, c0_pc, c1_inst, c1_pc;
  logic        c1_use, c0_nop, c1_nop;
  slot_t       nxt_even, nxt_odd;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    c0_inst  = first_inst;
    c0_pc    = pc_in;
    c1_inst  = second_inst;
    c1_pc    = second_pc;
    c1_use   = !hazard;
    if (state == HOLD) begin
      c0_inst = hold_inst;
      c0_pc   = hold_pc;
      c1_use  = 1'b0;
    end
    c0_nop   = is_nop(c0_inst[31:21]);
    c1_nop   = is_nop(c1_inst[31:21]);
    nxt_even = '{inst: NOP_EVEN, pc: 32'd0, valid: 1'b0};
    nxt_odd  = '{inst: NOP_ODD,  pc: 32'd0, valid: 1'b0};
    // Place nops before real instructions so a real one always wins a shared slot.
    if (c0_nop) begin
      if (c0_inst[30]) nxt_odd = '{c0_inst, c0_pc, 1'b0};
      else             nxt_even = '{c0_inst, c0_pc, 1'b0};
    end
    if (c1_use && c1_nop) begin
      if (c1_inst[30]) nxt_odd = '{c1_inst, c1_pc, 1'b0};
      else             nxt_even = '{c1_inst, c1_pc, 1'b0};
    end
    if (!c0_nop) begin
      if (c0_inst[30]) nxt_odd = '{c0_inst, c0_pc, 1'b1};
      else             nxt_even = '{c0_inst, c0_pc, 1'b1};
    end
    if (c1_use && !c1_nop) begin
      if (c1_inst[30]) nxt_odd = '{c1_inst, c1_pc, 1'b1};
      else             nxt_even = '{c1_inst, c1_pc, 1'b1};
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= PAIR;
      hold_inst  <= 32'd0;
      hold_pc    <= 32'd0;
      even_inst  <= NOP_EVEN;
      even_pc    <= 32'd0;
      even_valid <= 1'b0;
      odd_inst   <= NOP_ODD;
      odd_pc     <= 32'd0;
      odd_valid  <= 1'b0;
    end else if (flush) begin
      state      <= PAIR;
      hold_inst  <= 32'd0;
      hold_pc    <= 32'd0;
      even_inst  <= NOP_EVEN;
      even_pc    <= 32'd0;
      even_valid <= 1'b0;
      odd_inst   <= NOP_ODD;
      odd_pc     <= 32'd0;
      odd_valid  <= 1'b0;
    end else if (!stall_in) begin
      even_inst  <= nxt_even.inst;
      even_pc    <= nxt_even.pc;
      even_valid <= nxt_even.valid;
      odd_inst   <= nxt_odd.inst;
      odd_pc     <= nxt_odd.pc;
      odd_valid  <= nxt_odd.valid;
      if (state == HOLD) begin
        state <= PAIR;
      end else if (hazard) begin
        state     <= HOLD;
        hold_inst <= second_inst;
        hold_pc   <= second_pc;
      end
    end
  end

`ifdef ISSUE_STATS_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dual_issue_cnt   <= 32'd0;
      single_issue_cnt <= 32'd0;
    end else if (!flush && !stall_in) begin
      if (nxt_even.valid && nxt_odd.valid && (dual_issue_cnt != 32'hFFFF_FFFF))
        dual_issue_cnt <= dual_issue_cnt + 32'd1;
      if ((nxt_even.valid ^ nxt_odd.valid) && (single_issue_cnt != 32'hFFFF_FFFF))
        single_issue_cnt <= single_issue_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dual_issue_stage.sv
// Directed self-checking bench for dual_issue_stage: pairing, swapping, hazard splits, flush, stall and reset.
module tb_dual_issue_stage;

  localparam logic [31:0] NOP_EVEN = 32'h0020_0000;
  localparam logic [31:0] NOP_ODD  = 32'h4020_0000;

  // Hand-decoded vectors (rt = bits[6:0], ra = [13:7], rb = [20:14], pipe bit = [30]).
  localparam logic [31:0] EV_A  = 32'h0C21_0183; // even, rt=3, ra=3, rb=4
  localparam logic [31:0] OD_B  = 32'h4800_0305; // odd,  rt=5, ra=6, rb=0
  localparam logic [31:0] EV_C  = 32'h0800_4102; // even, rt=2, ra=2, rb=1
  localparam logic [31:0] EV_R5 = 32'h0C21_0185; // even, rt=5
  localparam logic [31:0] OD_RA5 = 32'h4800_0281; // odd,  ra=5, rb=0

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] first_inst, second_inst, pc_in;
  logic        flush, stall_in;
  logic        stall_out;
  logic [31:0] even_inst, even_pc, odd_inst, odd_pc;
  logic        even_valid, odd_valid;
`ifdef ISSUE_STATS_EN
  logic [31:0] dual_issue_cnt, single_issue_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  dual_issue_stage dut (
    .clock(clock), .reset(reset),
    .first_inst(first_inst), .second_inst(second_inst), .pc_in(pc_in),
    .flush(flush), .stall_in(stall_in), .stall_out(stall_out),
    .even_inst(even_inst), .even_pc(even_pc), .even_valid(even_valid),
    .odd_inst(odd_inst), .odd_pc(odd_pc), .odd_valid(odd_valid)
`ifdef ISSUE_STATS_EN
    , .dual_issue_cnt(dual_issue_cnt), .single_issue_cnt(single_issue_cnt)
`endif
  );

  task automatic drive(input logic [31:0] f, input logic [31:0] s, input logic [31:0] p);
    first_inst  = f;
    second_inst = s;
    pc_in       = p;
    #1;
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; flush = 1'b0; stall_in = 1'b0;
    drive(NOP_EVEN, NOP_ODD, 32'd0);
    checks++;
    if ({even_inst, even_pc, even_valid, odd_inst, odd_pc, odd_valid} !==
        {NOP_EVEN, 32'd0, 1'b0, NOP_ODD, 32'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset_outputs: got %h/%h/%b %h/%h/%b", even_inst, even_pc, even_valid, odd_inst, odd_pc, odd_valid);
    end
    checks++;
    if (stall_out !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", stall_out); end
    tick;
    reset = 1'b0;
  endtask

  task automatic test_even_odd_pair;
    drive(EV_A, OD_B, 32'h10);
    checks++;
    if (stall_out !== 1'b0) begin errors++; $display("FAIL pair_stall: got %b want 0", stall_out); end
    tick;
    checks++;
    if ({even_inst, even_pc, even_valid, odd_inst, odd_pc, odd_valid} !== {EV_A, 32'h10, 1'b1, OD_B, 32'h14, 1'b1}) begin
      errors++;
      $display("FAIL pair_out: got %h/%h/%b %h/%h/%b", even_inst, even_pc, even_valid, odd_inst, odd_pc, odd_valid);
    end
  endtask

  task automatic test_swapped;
    drive(OD_B, EV_A, 32'h10);
    checks++;
    if (stall_out !== 1'b0) begin errors++; $display("FAIL swap_stall: got %b want 0", stall_out); end
    tick;
    checks++;
    if ({even_inst, even_pc, even_valid, odd_inst, odd_pc, odd_valid} !== {EV_A, 32'h14, 1'b1, OD_B, 32'h10, 1'b1}) begin
      errors++;
      $display("FAIL swap_out: got %h/%h/%b %h/%h/%b", even_inst, even_pc, even_valid, odd_inst, odd_pc, odd_valid);
    end
  endtask

  task automatic test_structural;
    drive(EV_A, EV_C, 32'h100);
    checks++;
    if (stall_out !== 1'b1) begin errors++; $display("FAIL struct_stall1: got %b want 1", stall_out); end
    tick;
    checks++;
    if ({even_inst, even_pc, even_valid, odd_inst, odd_valid} !== {EV_A, 32'h100, 1'b1, NOP_ODD, 1'b0}) begin
      errors++;
      $display("FAIL struct_out1: got %h/%h/%b %h/%b", even_inst, even_pc, even_valid, odd_inst, odd_valid);
    end
    // The pair presented during HOLD must be ignored.
    drive(EV_A, OD_B, 32'h108);
    checks++;
    if (stall_out !== 1'b0) begin errors++; $display("FAIL struct_stall2: got %b want 0", stall_out); end
    tick;
    checks++;
    if ({even_inst, even_pc, even_valid, odd_inst, odd_valid} !== {EV_C, 32'h104, 1'b1, NOP_ODD, 1'b0}) begin
      errors++;
      $display("FAIL struct_out2: got %h/%h/%b %h/%b", even_inst, even_pc, even_valid, odd_inst, odd_valid);
    end
  endtask

  task automatic test_raw;
    drive(EV_R5, OD_RA5, 32'h200);
    checks++;
    if (stall_out !== 1'b1) begin errors++; $display("FAIL raw_stall1: got %b want 1", stall_out); end
    tick;
    checks++;
    if ({even_inst, even_pc, even_valid, odd_inst, odd_valid} !== {EV_R5, 32'h200, 1'b1, NOP_ODD, 1'b0}) begin
      errors++;
      $display("FAIL raw_out1: got %h/%h/%b %h/%b", even_inst, even_pc, even_valid, odd_inst, odd_valid);
    end
    drive(NOP_EVEN, NOP_ODD, 32'h208);
    tick;
    checks++;
    if ({even_inst, even_valid, odd_inst, odd_pc, odd_valid} !== {NOP_EVEN, 1'b0, OD_RA5, 32'h204, 1'b1}) begin
      errors++;
      $display("FAIL raw_out2: got %h/%b %h/%h/%b", even_inst, even_valid, odd_inst, odd_pc, odd_valid);
    end
  endtask

  task automatic test_nop_pair;
    // A nop in the same pipe as a real instruction is not a hazard and must not displace it.
    drive(EV_A, NOP_EVEN, 32'h300);
    checks++;
    if (stall_out !== 1'b0) begin errors++; $display("FAIL nop_stall: got %b want 0", stall_out); end
    tick;
    checks++;
    if ({even_inst, even_pc, even_valid, odd_inst, odd_valid} !== {EV_A, 32'h300, 1'b1, NOP_ODD, 1'b0}) begin
      errors++;
      $display("FAIL nop_out: got %h/%h/%b %h/%b", even_inst, even_pc, even_valid, odd_inst, odd_valid);
    end
  endtask

  task automatic test_pc_wrap;
    drive(OD_B, OD_B, 32'hFFFF_FFFC);
    tick;
    drive(NOP_EVEN, NOP_ODD, 32'h0);
    tick;
    checks++;
    if ({odd_inst, odd_pc, odd_valid, even_valid} !== {OD_B, 32'h0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL wrap_out: got %h/%h/%b even_valid=%b", odd_inst, odd_pc, odd_valid, even_valid);
    end
  endtask

  task automatic test_flush_in_hold;
    drive(EV_A, EV_C, 32'h400);
    tick;
    flush = 1'b1;
    #1;
    checks++;
    if (stall_out !== 1'b0) begin errors++; $display("FAIL flush_stall: got %b want 0", stall_out); end
    tick;
    flush = 1'b0;
    checks++;
    if ({even_inst, even_valid, odd_inst, odd_valid, stall_out} !== {NOP_EVEN, 1'b0, NOP_ODD, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL flush_out: got %h/%b %h/%b stall=%b", even_inst, even_valid, odd_inst, odd_valid, stall_out);
    end
    drive(NOP_EVEN, NOP_ODD, 32'h408);
    tick;
    checks++;
    if ({even_inst, even_valid, odd_inst, odd_valid} !== {NOP_EVEN, 1'b0, NOP_ODD, 1'b0}) begin
      errors++;
      $display("FAIL flush_no_held: got %h/%b %h/%b", even_inst, even_valid, odd_inst, odd_valid);
    end
  endtask

  task automatic test_stall_in;
    drive(EV_A, OD_B, 32'h500);
    tick;
    stall_in = 1'b1;
    drive(OD_B, EV_C, 32'h600);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (stall_out !== 1'b1) begin errors++; $display("FAIL stall_out_%0d: got %b want 1", i, stall_out); end
      tick;
      checks++;
      if ({even_inst, even_pc, even_valid, odd_inst, odd_pc, odd_valid} !== {EV_A, 32'h500, 1'b1, OD_B, 32'h504, 1'b1}) begin
        errors++;
        $display("FAIL stall_frozen_%0d: got %h/%h/%b %h/%h/%b", i, even_inst, even_pc, even_valid, odd_inst, odd_pc, odd_valid);
      end
    end
    stall_in = 1'b0;
  endtask

  task automatic test_reset_in_hold;
    drive(EV_A, EV_C, 32'h700);
    tick;
    #2;
    reset = 1'b1;
    drive(NOP_EVEN, NOP_ODD, 32'h0);
    checks++;
    if ({even_inst, even_pc, even_valid, odd_inst, odd_pc, odd_valid, stall_out} !==
        {NOP_EVEN, 32'd0, 1'b0, NOP_ODD, 32'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL hold_reset: got %h/%h/%b %h/%h/%b stall=%b", even_inst, even_pc, even_valid, odd_inst, odd_pc, odd_valid, stall_out);
    end
    reset = 1'b0;
    drive(EV_A, OD_B, 32'h800);
    tick;
    checks++;
    if ({even_inst, even_pc, even_valid, odd_inst, odd_pc, odd_valid} !== {EV_A, 32'h800, 1'b1, OD_B, 32'h804, 1'b1}) begin
      errors++;
      $display("FAIL hold_reset_pair: got %h/%h/%b %h/%h/%b", even_inst, even_pc, even_valid, odd_inst, odd_pc, odd_valid);
    end
  endtask

  initial begin
    test_reset;
    test_even_odd_pair;
    test_swapped;
    test_structural;
    test_raw;
    test_nop_pair;
    test_pc_wrap;
    test_flush_in_hold;
    test_stall_in;
    test_reset_in_hold;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
